m68k_bus_responder: RTL and testbench
=====================================

M68K_BUS_RESPONDER -- requirements
Module: m68k_bus_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, SHALL set the word-address width taken from eab.
REQ-002 Parameter WAIT_STATES, default 0, SHALL set the extra clk cycles inserted between peripheral ack and DTACK assertion.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the number of clk cycles allowed for ack before bus error.
REQ-004 clk  in  1  system clock; all logic on rising edge; single clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cs  in  1  address-decode select for this responder.
REQ-007 as_n, uds_n, lds_n, rw  in  1 each  68000 address strobe, upper/lower data strobes, read=1/write=0.
REQ-008 addr  in  ADDR_WIDTH  CPU word address; cpu_dout  in  16  CPU write data.
REQ-009 dtack_n  out  1  data transfer acknowledge to CPU; berr_n  out  1  bus error to CPU.
REQ-010 cpu_din  out  16  read data to CPU.
REQ-011 req  out  1; we  out  1; mask  out  2 (bit1=upper, bit0=lower); paddr  out  ADDR_WIDTH; pdata_out  out  16  peripheral-side request.
REQ-012 ack  in  1; pdata_in  in  16  peripheral completion and read data.

Function
REQ-013 FSM states SHALL be IDLE, REQ, DELAY, DONE, ERR.
REQ-014 IDLE: when cs=1, as_n=0 and (uds_n=0 or lds_n=0) at an edge, SHALL latch addr->paddr, !rw->we, {!uds_n,!lds_n}->mask, cpu_dout->pdata_out, set req=1, enter REQ.
REQ-015 IDLE SHALL ignore as_n=0 with both strobes high (write strobe lag); no request issued.
REQ-016 REQ: req SHALL stay 1 until ack=1 is sampled; ack is ignored in all other states.
REQ-017 On ack in REQ: req SHALL drop next edge; if read, pdata_in SHALL be captured into cpu_din on that edge; enter DELAY if WAIT_STATES>0, else DONE.
REQ-018 DELAY SHALL count exactly WAIT_STATES cycles then enter DONE.
REQ-019 Latency: strobe sampled at edge 0, ack present at edge 1, WAIT_STATES=0 -> dtack_n=0 after edge 1; each wait state adds one cycle.
REQ-020 DONE: dtack_n SHALL be 0 and cpu_din stable until as_n=1 is sampled; then dtack_n=1, enter IDLE the same edge.
REQ-021 Back-to-back: a new cycle SHALL NOT start in the edge that leaves DONE; earliest start is the following edge.
REQ-022 as_n deasserted while in REQ/DELAY: peripheral transaction SHALL complete (req held until ack), then return to IDLE without asserting dtack_n; cpu_din still updated on reads.
REQ-023 Writes SHALL leave cpu_din unchanged; byte cycles pass mask unchanged, full 16-bit pdata_in returned on reads.
REQ-024 dtack_n and berr_n SHALL never be 0 simultaneously.

Reset
REQ-025 reset SHALL force IDLE, dtack_n=1, berr_n=1, req=0, we=0, mask=0, paddr=0, pdata_out=0, cpu_din=0, counters=0.
REQ-026 reset mid-transaction SHALL drop req on that edge; a subsequent ack SHALL be ignored.

Configuration
REQ-027 Macro M68K_BUS_RESPONDER_BERR_TIMEOUT_EN defined: a counter SHALL run in REQ; ack absent for TIMEOUT cycles -> req=0, berr_n=0, enter ERR; ERR holds berr_n=0 until as_n=1, then IDLE.
REQ-028 ack arriving on the same edge the timeout expires SHALL win (normal completion).
REQ-029 Macro undefined: berr_n SHALL be constant 1, no timeout counter, REQ waits indefinitely.

Verification
REQ-030 Read, WAIT_STATES=0, ack one cycle after req, pdata_in=16'hBEEF -> dtack_n low 1 cycle after ack edge, cpu_din=16'hBEEF, req high exactly 1 cycle.
REQ-031 Byte write lds_n=0, uds_n=1, addr=11'h123, cpu_dout=16'h00A5 -> we=1, mask=2'b01, paddr=11'h123, pdata_out=16'h00A5; dtack_n released 1 cycle after as_n rises.
REQ-032 WAIT_STATES=3, read with immediate ack -> dtack_n asserts exactly 3 cycles later than the WAIT_STATES=0 case.
REQ-033 Macro defined, TIMEOUT=8, ack never asserted -> berr_n=0 after 8 cycles in REQ, req=0, dtack_n stays 1; berr_n=1 after as_n rises.
REQ-034 reset asserted with req=1, then ack pulsed -> outputs at reset values, no dtack_n assertion, next cycle completes normally.

Source files
------------

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: turns 68000 asynchronous bus cycles into a registered req/ack peripheral port.
// Optional bus-error timeout: define M68K_BUS_RESPONDER_BERR_TIMEOUT_EN.
module m68k_bus_responder #(
   parameter int unsigned ADDR_WIDTH  = 11,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  as_n,
   input  logic                  uds_n,
   input  logic                  lds_n,
   input  logic                  rw,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [15:0]           cpu_dout,
   output logic                  dtack_n,
   output logic                  berr_n,
   output logic [15:0]           cpu_din,
   output logic                  req,
   output logic                  we,
   output logic [1:0]            mask,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [15:0]           pdata_out,
   input  logic                  ack,
   input  logic [15:0]           pdata_in
);

   typedef enum logic [2:0] {IDLE, REQ, DELAY, DONE, ERR} state_t;

   // Wait-state counter runs 0..WAIT_STATES-1; sized to at least one bit so WAIT_STATES=0 still elaborates.
   localparam int unsigned   WCW       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_t                  state_q, state_d;
   logic                    req_d, we_d, dtack_n_d;
   logic [1:0]              mask_d;
   logic [ADDR_WIDTH-1:0]   paddr_d;
   logic [15:0]             pdata_out_d, cpu_din_d;
   logic [WCW-1:0]          wait_cnt_q, wait_cnt_d;
   logic                    aborted_q, aborted_d;
   logic                    start;
   logic                    cpu_gone;

`ifdef M68K_BUS_RESPONDER_BERR_TIMEOUT_EN
   localparam int unsigned   TCW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TCW-1:0] TO_LAST = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [TCW-1:0] to_cnt_q, to_cnt_d;
   logic           berr_n_q, berr_n_d;

   assign berr_n = berr_n_q;
`else
   assign berr_n = 1'b1;
`endif

   // A cycle starts only once a data strobe is present; AS alone precedes the strobes on writes.
   assign start    = cs & ~as_n & (~uds_n | ~lds_n);
   // CPU has abandoned the cycle if AS is seen high now or was seen high earlier in this transaction.
   assign cpu_gone = aborted_q | as_n;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d     = state_q;
      req_d       = req;
      we_d        = we;
      mask_d      = mask;
      paddr_d     = paddr;
      pdata_out_d = pdata_out;
      cpu_din_d   = cpu_din;
      dtack_n_d   = dtack_n;
      wait_cnt_d  = wait_cnt_q;
      aborted_d   = aborted_q;
`ifdef M68K_BUS_RESPONDER_BERR_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
      berr_n_d    = berr_n_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (start) begin
               paddr_d     = addr;
               we_d        = ~rw;
               mask_d      = {~uds_n, ~lds_n};
               pdata_out_d = cpu_dout;
               req_d       = 1'b1;
               aborted_d   = 1'b0;
               wait_cnt_d  = '0;
`ifdef M68K_BUS_RESPONDER_BERR_TIMEOUT_EN
               to_cnt_d    = '0;
`endif
               state_d     = REQ;
            end
         end

         REQ: begin
            if (as_n) aborted_d = 1'b1;
            // ack is checked first so it wins over a timeout expiring on the same edge.
            if (ack) begin
               req_d      = 1'b0;
               wait_cnt_d = '0;
               if (!we) cpu_din_d = pdata_in;
               if (WAIT_STATES > 0) begin
                  state_d = DELAY;
               end else if (cpu_gone) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DONE;
                  dtack_n_d = 1'b0;
               end
            end
`ifdef M68K_BUS_RESPONDER_BERR_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               req_d    = 1'b0;
               berr_n_d = 1'b0;
               state_d  = ERR;
            end else begin
               to_cnt_d = to_cnt_q + TCW'(1);
            end
`endif
         end

         DELAY: begin
            if (as_n) aborted_d = 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
               if (cpu_gone) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DONE;
                  dtack_n_d = 1'b0;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end

         DONE: begin
            if (as_n) begin
               dtack_n_d = 1'b1;
               state_d   = IDLE;
            end
         end

         ERR: begin
`ifdef M68K_BUS_RESPONDER_BERR_TIMEOUT_EN
            if (as_n) begin
               berr_n_d = 1'b1;
               state_d  = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state_q    <= IDLE;
         req        <= 1'b0;
         we         <= 1'b0;
         mask       <= 2'b00;
         paddr      <= '0;
         pdata_out  <= '0;
         cpu_din    <= '0;
         dtack_n    <= 1'b1;
         wait_cnt_q <= '0;
         aborted_q  <= 1'b0;
`ifdef M68K_BUS_RESPONDER_BERR_TIMEOUT_EN
         to_cnt_q   <= '0;
         berr_n_q   <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         req        <= req_d;
         we         <= we_d;
         mask       <= mask_d;
         paddr      <= paddr_d;
         pdata_out  <= pdata_out_d;
         cpu_din    <= cpu_din_d;
         dtack_n    <= dtack_n_d;
         wait_cnt_q <= wait_cnt_d;
         aborted_q  <= aborted_d;
`ifdef M68K_BUS_RESPONDER_BERR_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
         berr_n_q   <= berr_n_d;
`endif
      end
   end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: WAIT_STATES=0 instance (TIMEOUT=8) plus a WAIT_STATES=3 instance.
module tb_m68k_bus_responder;

   logic        clk = 1'b0;
   logic        reset, cs, cs_ws, as_n, uds_n, lds_n, rw, ack, ack_ws;
   logic [10:0] addr;
   logic [15:0] cpu_dout, pdata_in;

   logic        dtack_n, berr_n, req, we;
   logic [1:0]  mask;
   logic [10:0] paddr;
   logic [15:0] cpu_din, pdata_out;

   logic        dtack_n_ws, berr_n_ws, req_ws, we_ws;
   logic [1:0]  mask_ws;
   logic [10:0] paddr_ws;
   logic [15:0] cpu_din_ws, pdata_out_ws;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   m68k_bus_responder #(.ADDR_WIDTH(11), .WAIT_STATES(0), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .cs(cs), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
      .addr(addr), .cpu_dout(cpu_dout), .dtack_n(dtack_n), .berr_n(berr_n), .cpu_din(cpu_din),
      .req(req), .we(we), .mask(mask), .paddr(paddr), .pdata_out(pdata_out),
      .ack(ack), .pdata_in(pdata_in)
   );

   m68k_bus_responder #(.ADDR_WIDTH(11), .WAIT_STATES(3), .TIMEOUT(255)) dut_ws (
      .clk(clk), .reset(reset), .cs(cs_ws), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
      .addr(addr), .cpu_dout(cpu_dout), .dtack_n(dtack_n_ws), .berr_n(berr_n_ws), .cpu_din(cpu_din_ws),
      .req(req_ws), .we(we_ws), .mask(mask_ws), .paddr(paddr_ws), .pdata_out(pdata_out_ws),
      .ack(ack_ws), .pdata_in(pdata_in)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle so registered outputs are sampled away from the edge.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_release();
      as_n  = 1'b1;
      uds_n = 1'b1;
      lds_n = 1'b1;
      cs    = 1'b0;
      cs_ws = 1'b0;
   endtask

   task automatic bus_start(input logic sel_ws, input logic read, input logic u, input logic l,
                            input logic [10:0] a, input logic [15:0] d);
      cs       = ~sel_ws;
      cs_ws    = sel_ws;
      as_n     = 1'b0;
      uds_n    = ~u;
      lds_n    = ~l;
      rw       = read;
      addr     = a;
      cpu_dout = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ack = 1'b0; ack_ws = 1'b0; rw = 1'b1; addr = '0; cpu_dout = '0; pdata_in = '0;
      bus_release();
      tick(2);
      check("rst_dtack", dtack_n, 1);
      check("rst_berr", berr_n, 1);
      check("rst_req", req, 0);
      check("rst_we", we, 0);
      check("rst_mask", mask, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pdata_out", pdata_out, 0);
      check("rst_cpu_din", cpu_din, 0);
      reset = 1'b0;
      tick();

      // Word read, ack one cycle after req
      bus_start(1'b0, 1'b1, 1'b1, 1'b1, 11'h055, 16'h0000);
      tick();
      check("rd_req_set", req, 1);
      check("rd_we", we, 0);
      check("rd_mask", mask, 2'b11);
      check("rd_paddr", paddr, 11'h055);
      check("rd_dtack_early", dtack_n, 1);
      ack = 1'b1; pdata_in = 16'hBEEF;
      tick();
      check("rd_req_drop", req, 0);
      check("rd_dtack", dtack_n, 0);
      check("rd_cpu_din", cpu_din, 16'hBEEF);
      check("rd_no_berr", berr_n, 1);
      ack = 1'b0; pdata_in = 16'h0000;
      tick();
      check("rd_dtack_hold", dtack_n, 0);
      check("rd_din_hold", cpu_din, 16'hBEEF);
      bus_release();
      tick();
      check("rd_dtack_release", dtack_n, 1);

      // Byte write with strobe lag: AS first, LDS one cycle later
      bus_start(1'b0, 1'b0, 1'b0, 1'b0, 11'h123, 16'h00A5);
      tick();
      check("wr_lag_no_req", req, 0);
      lds_n = 1'b0;
      tick();
      check("wr_req", req, 1);
      check("wr_we", we, 1);
      check("wr_mask", mask, 2'b01);
      check("wr_paddr", paddr, 11'h123);
      check("wr_pdata_out", pdata_out, 16'h00A5);
      ack = 1'b1; pdata_in = 16'h1111;
      tick();
      check("wr_dtack", dtack_n, 0);
      check("wr_din_unchanged", cpu_din, 16'hBEEF);
      ack = 1'b0;
      bus_release();
      tick();
      check("wr_dtack_release", dtack_n, 1);

      // Upper-byte read at top address, started on the edge right after leaving DONE; ack delayed
      bus_start(1'b0, 1'b1, 1'b1, 1'b0, 11'h7FF, 16'h0000);
      tick();
      check("b2b_req", req, 1);
      check("ub_mask", mask, 2'b10);
      check("ub_paddr", paddr, 11'h7FF);
      tick(2);
      check("ub_req_wait", req, 1);
      check("ub_no_dtack", dtack_n, 1);
      ack = 1'b1; pdata_in = 16'hA55A;
      tick();
      check("ub_full_word", cpu_din, 16'hA55A);
      check("ub_dtack", dtack_n, 0);
      ack = 1'b0;
      bus_release();
      tick();

      // CPU drops AS while the peripheral is still busy
      bus_start(1'b0, 1'b1, 1'b1, 1'b1, 11'h001, 16'h0000);
      tick();
      check("ab_req", req, 1);
      bus_release();
      tick();
      check("ab_req_held", req, 1);
      ack = 1'b1; pdata_in = 16'hCAFE;
      tick();
      check("ab_req_drop", req, 0);
      check("ab_no_dtack", dtack_n, 1);
      check("ab_cpu_din", cpu_din, 16'hCAFE);
      ack = 1'b0;
      tick();
      check("ab_idle_dtack", dtack_n, 1);

      // Reset in the middle of a transaction, then a stray ack
      bus_start(1'b0, 1'b1, 1'b1, 1'b1, 11'h0AA, 16'h0000);
      tick();
      check("mr_req", req, 1);
      reset = 1'b1;
      tick();
      check("mr_req_drop", req, 0);
      check("mr_paddr", paddr, 0);
      check("mr_mask", mask, 0);
      check("mr_cpu_din", cpu_din, 0);
      reset = 1'b0;
      bus_release();
      ack = 1'b1; pdata_in = 16'h1234;
      tick();
      check("mr_stray_dtack", dtack_n, 1);
      check("mr_stray_din", cpu_din, 0);
      ack = 1'b0;
      bus_start(1'b0, 1'b1, 1'b1, 1'b1, 11'h0AA, 16'h0000);
      tick();
      check("mr_next_req", req, 1);
      ack = 1'b1; pdata_in = 16'h5678;
      tick();
      check("mr_next_dtack", dtack_n, 0);
      check("mr_next_din", cpu_din, 16'h5678);
      ack = 1'b0;
      bus_release();
      tick();

      // WAIT_STATES=3: DTACK three edges later than the zero-wait case
      bus_start(1'b1, 1'b1, 1'b1, 1'b1, 11'h200, 16'h0000);
      tick();
      check("ws_req", req_ws, 1);
      check("ws_other_idle", req, 0);
      ack_ws = 1'b1; pdata_in = 16'hBEEF;
      tick();
      check("ws_req_drop", req_ws, 0);
      check("ws_din_on_ack", cpu_din_ws, 16'hBEEF);
      check("ws_dtack_e1", dtack_n_ws, 1);
      ack_ws = 1'b0;
      tick(2);
      check("ws_dtack_e3", dtack_n_ws, 1);
      tick();
      check("ws_dtack_e4", dtack_n_ws, 0);
      check("ws_berr", berr_n_ws, 1);
      bus_release();
      tick();
      check("ws_dtack_release", dtack_n_ws, 1);

      // No ack at all
      bus_start(1'b0, 1'b1, 1'b1, 1'b1, 11'h300, 16'h0000);
      tick();
      check("to_req", req, 1);
`ifdef M68K_BUS_RESPONDER_BERR_TIMEOUT_EN
      tick(7);
      check("to_berr_before", berr_n, 1);
      check("to_req_before", req, 1);
      tick();
      check("to_berr", berr_n, 0);
      check("to_req_drop", req, 0);
      check("to_no_dtack", dtack_n, 1);
      tick();
      check("to_berr_hold", berr_n, 0);
      bus_release();
      tick();
      check("to_berr_release", berr_n, 1);
`else
      tick(20);
      check("nt_berr", berr_n, 1);
      check("nt_req_held", req, 1);
      check("nt_no_dtack", dtack_n, 1);
      ack = 1'b1; pdata_in = 16'h0F0F;
      tick();
      check("nt_late_dtack", dtack_n, 0);
      check("nt_late_din", cpu_din, 16'h0F0F);
      ack = 1'b0;
      bus_release();
      tick();
      check("nt_release", dtack_n, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
